// File: rtl/round_robin_mux_arbiter_pkg.sv
// Shared types and default sizing for the round-robin mux arbiter.
// The output stage is either holding a word (FULL) or not (EMPTY).
package round_robin_mux_arbiter_pkg;
  localparam int DEF_N_REQ = 4;
  localparam int DEF_WIDTH = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;
endpackage

// File: rtl/round_robin_mux_arbiter_select.sv
// Rotating-priority winner search: first asserted request at or after ptr,
// wrapping modulo N_REQ. Returns one-hot grant, binary index and an any flag.
module rr_priority_select #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);
  int j;

  // Scan from the farthest offset back to ptr so the nearest request wins.
  always_comb begin
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (req[j]) begin
        idx = IDX_W'(j);
        any = 1'b1;
      end
    end
  end

  always_comb begin
    grant = '0;
    for (int i = 0; i < N_REQ; i++) begin
      grant[i] = any && (idx == IDX_W'(i));
    end
  end
endmodule

// File: rtl/round_robin_mux_arbiter.sv
// N_REQ:1 round-robin arbiter feeding a single registered output slot that
// can drain and reload in the same cycle, giving one word per cycle.
module round_robin_mux_arbiter
  import round_robin_mux_arbiter_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         in_valid,
  input  logic [N_REQ*WIDTH-1:0]   in_data,
  output logic [N_REQ-1:0]         in_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(N_REQ)-1:0] out_src,
  input  logic                     out_ready
);
  localparam int IDX_W = $clog2(N_REQ);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N_REQ-1:0] grant;
  logic [IDX_W-1:0] win_idx;
  logic             win_any;
  logic             can_load, load;
  logic [WIDTH-1:0] win_data;
  logic [WIDTH-1:0] data_p1;
  logic [IDX_W-1:0] src_p1;

  rr_priority_select #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_sel (
    .req   (in_valid),
    .ptr   (ptr_q),
    .grant (grant),
    .idx   (win_idx),
    .any   (win_any)
  );

  // Reset forces ready low so nothing is consumed in a reset cycle.
  assign can_load = !rst && ((state_q == EMPTY) || out_ready);
  assign load     = can_load && win_any;
  assign in_ready = load ? grant : '0;
  assign ptr_d    = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + IDX_W'(1);

  always_comb begin
    win_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx == IDX_W'(i)) win_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (load) state_d = FULL;
      FULL:    if (load) state_d = FULL;
               else if (out_ready) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  // ---- stage p1: registered winner word, source index and rotation pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      data_p1 <= '0;
      src_p1  <= '0;
      ptr_q   <= '0;
    end else if (load) begin
      data_p1 <= win_data;
      src_p1  <= win_idx;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_p1;
  assign out_src   = src_p1;
endmodule

// File: tb/tb_round_robin_mux_arbiter.sv
// Random and directed stimulus for round_robin_mux_arbiter, checked each
// cycle against a transaction-level model of the arbiter and output slot.
module tb_round_robin_mux_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk;
  logic           rst;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [1:0]     out_src;
  logic           out_ready;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: whether the slot holds a word, which word, and the pointer.
  bit         m_full;
  logic [W-1:0] m_data;
  int         m_src;
  int         m_ptr;

  round_robin_mux_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int find_winner(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N*W-1:0] ramp_data();
    logic [N*W-1:0] d;
    for (int i = 0; i < N; i++) d[i*W +: W] = 8'h10 + 8'(i);
    return d;
  endfunction

  // One clock: apply inputs mid-cycle, check against the model, advance model at the edge.
  task automatic cycle(input logic [N-1:0] v, input logic [N*W-1:0] d,
                       input logic ordy, input logic r);
    int   w;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    rst       = r;
    #1;
    w = find_winner(v, m_ptr);
    exp_rdy = '0;
    if (!r && (!m_full || ordy) && w >= 0) exp_rdy[w] = 1'b1;
    chk("in_ready",  32'(in_ready),  32'(exp_rdy));
    chk("out_valid", 32'(out_valid), 32'(m_full));
    chk("out_data",  32'(out_data),  32'(m_data));
    chk("out_src",   32'(out_src),   32'(m_src));
    @(posedge clk);
    if (r) begin
      m_full = 1'b0; m_data = '0; m_src = 0; m_ptr = 0;
    end else if (exp_rdy != '0) begin
      m_full = 1'b1;
      m_data = d[w*W +: W];
      m_src  = w;
      m_ptr  = (w + 1) % N;
    end else if (m_full && ordy) begin
      m_full = 1'b0;
    end
  endtask

  initial begin
    logic [N*W-1:0] ramp;
    ramp = ramp_data();
    m_full = 1'b0; m_data = '0; m_src = 0; m_ptr = 0;
    rst = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b0;

    // Reset held two cycles with everything active.
    cycle(4'hF, ramp, 1'b1, 1'b1);
    cycle(4'hF, ramp, 1'b1, 1'b1);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);

    // Full request load: strict rotation 0..3 twice, one word per cycle.
    for (int k = 0; k < 8; k++) begin
      cycle(4'hF, ramp, 1'b1, 1'b0);
      #1;
      chk("rot_src", 32'(out_src), 32'(k % 4));
      chk("rot_vld", 32'(out_valid), 32'd1);
    end
    cycle(4'h0, ramp, 1'b1, 1'b0);

    // Single requester 2, then 3 must beat 0.
    cycle(4'b0100, ramp, 1'b1, 1'b0);
    #1;
    chk("single_data", 32'(out_data), 32'h12);
    chk("single_src",  32'(out_src),  32'd2);
    cycle(4'b1001, ramp, 1'b1, 1'b0);
    #1;
    chk("after2_src", 32'(out_src), 32'd3);

    // Stall with full slot, then drain and reload in one cycle.
    cycle(4'hF, ramp, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) cycle(4'hF, ramp, 1'b0, 1'b0);
    cycle(4'hF, ramp, 1'b1, 1'b0);
    #1;
    chk("drain_load_vld", 32'(out_valid), 32'd1);

    // Winner 3 wraps pointer to 0.
    cycle(4'h0, ramp, 1'b1, 1'b0);
    cycle(4'b1000, ramp, 1'b1, 1'b0);
    cycle(4'b1001, ramp, 1'b1, 1'b0);
    #1;
    chk("wrap_src", 32'(out_src), 32'd0);

    // Reset while holding a stalled word.
    cycle(4'hF, ramp, 1'b0, 1'b0);
    cycle(4'hF, ramp, 1'b0, 1'b1);
    #1;
    chk("rst_full_vld", 32'(out_valid), 32'd0);

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      logic [N*W-1:0] rd;
      for (int i = 0; i < N; i++) rd[i*W +: W] = 8'($urandom);
      cycle(4'($urandom), rd, 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 39) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
